// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encodings, counter width default and Booth pair codes
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 4;

  // {Q[0], Qm1} pairs that modify the accumulator
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth step: add/sub M into A, then arithmetic shift {A,Q,Qm1}
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a_i;
    case ({q_i[0], qm1_i})
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      default:   sum = a_i;
    endcase
  end

  // A is one bit wider than the operands, so its MSB is a true sign bit for the shift
  assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o   = {sum[0], q_i[WIDTH-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - sequential Booth multiplier sequencer driving an external down-counter
// Optional feature: BOOTH_ZERO_SKIP_EN (zero operand completes without iterating)
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               cnt_ld,
  output logic [CNT_W-1:0]   cnt_init,
  output logic               cnt_dec,
  input  logic [CNT_W-1:0]   cnt_val
);

  state_t state_q, state_d;

  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH:0]       step_a;
  logic [WIDTH-1:0]     step_q;
  logic                 step_qm1;
  logic                 zero_ops;
  logic                 cnt_last;
  logic                 cnt_empty;

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_ops = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_ops = 1'b0;
`endif

  assign cnt_last  = (cnt_val == CNT_W'(1));
  assign cnt_empty = (cnt_val == '0);
  assign cnt_init  = CNT_W'(WIDTH);

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (step_a),
    .q_o   (step_q),
    .qm1_o (step_qm1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = zero_ops ? DONE : ITER;
        end
      end
      ITER: begin
        if (cnt_last || cnt_empty) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    cnt_ld  = (state_q == IDLE) && start && !zero_ops;
    cnt_dec = (state_q == ITER);
  end

  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = {multiplicand[WIDTH-1], multiplicand};
          q_d   = multiplier;
          a_d   = '0;
          qm1_d = 1'b0;
          if (zero_ops) begin
            product_d = '0;
          end
        end
      end
      ITER: begin
        // an unloaded counter aborts with whatever partial result is present
        if (cnt_empty) begin
          product_d = {a_q[WIDTH-1:0], q_q};
        end else begin
          a_d   = step_a;
          q_d   = step_q;
          qm1_d = step_qm1;
          if (cnt_last) begin
            product_d = {step_a[WIDTH-1:0], step_q};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - randomized self-checking bench for booth_seq_ctrl with a 4-bit counter alongside
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        cnt_ld;
  logic [3:0]  cnt_init;
  logic        cnt_dec;
  logic [3:0]  cnt_q;

  int n_cmp = 0;
  int n_fail = 0;
  bit zskip;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .cnt_ld       (cnt_ld),
    .cnt_init     (cnt_init),
    .cnt_dec      (cnt_dec),
    .cnt_val      (cnt_q)
  );

  // external iteration counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (cnt_ld) cnt_q <= cnt_init;
    else if (cnt_dec && cnt_q != 0) cnt_q <= cnt_q - 4'd1;
  end

  function automatic logic [15:0] ref_mul(input logic signed [7:0] m, input logic signed [7:0] q);
    int p;
    p = int'(m) * int'(q);
    return p[15:0];
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the first IDLE cycle after done.
  task automatic do_mult(input logic [7:0] m, input logic [7:0] q, output int done_cyc,
                         output int lds, output int decs, output logic [15:0] prod, output int ld_val);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    #1;
    lds = int'(cnt_ld);
    decs = int'(cnt_dec);
    ld_val = int'(cnt_init);
    done_cyc = -1;
    prod = 'x;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      #1;
      lds  += int'(cnt_ld);
      decs += int'(cnt_dec);
      if (done) begin
        done_cyc = c;
        prod = product;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
    n_cmp++; if (cnt_ld !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_ld got %b want 0", cnt_ld); end
    n_cmp++; if (cnt_dec !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_dec got %b want 0", cnt_dec); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    int dc, lds, decs, lv;
    logic [15:0] p;
    do_mult(8'sd3, -8'sd5, dc, lds, decs, p, lv);
    n_cmp++; if (lds !== 1) begin n_fail++; $display("FAIL basic_ld_count got %0d want 1", lds); end
    n_cmp++; if (lv !== 8) begin n_fail++; $display("FAIL basic_cnt_init got %0d want 8", lv); end
    n_cmp++; if (decs !== 8) begin n_fail++; $display("FAIL basic_dec_count got %0d want 8", decs); end
    n_cmp++; if (dc !== 9) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 9", dc); end
    n_cmp++; if (p !== 16'hFFF1) begin n_fail++; $display("FAIL basic_product got %h want fff1", p); end
    n_cmp++; if (product !== 16'hFFF1) begin n_fail++; $display("FAIL basic_product_held got %h want fff1", product); end
  endtask

  task automatic test_corners;
    int dc, lds, decs, lv;
    logic [15:0] p;
    do_mult(8'h80, 8'h80, dc, lds, decs, p, lv);
    n_cmp++; if (p !== 16'h4000) begin n_fail++; $display("FAIL corner_min_min got %h want 4000", p); end
    do_mult(8'h80, 8'h7F, dc, lds, decs, p, lv);
    n_cmp++; if (p !== 16'hC080) begin n_fail++; $display("FAIL corner_min_max got %h want c080", p); end
    do_mult(8'h7F, 8'h7F, dc, lds, decs, p, lv);
    n_cmp++; if (p !== ref_mul(8'h7F, 8'h7F)) begin n_fail++; $display("FAIL corner_max_max got %h want %h", p, ref_mul(8'h7F, 8'h7F)); end
  endtask

  task automatic test_random;
    int dc, lds, decs, lv, exp_dc;
    logic [7:0] m, q;
    logic [15:0] p;
    for (int i = 0; i < 25; i++) begin
      m = 8'($urandom);
      q = 8'($urandom);
      do_mult(m, q, dc, lds, decs, p, lv);
      exp_dc = (zskip && (m == 0 || q == 0)) ? 1 : 9;
      n_cmp++; if (p !== ref_mul(m, q)) begin n_fail++; $display("FAIL rand_product m=%h q=%h got %h want %h", m, q, p, ref_mul(m, q)); end
      n_cmp++; if (dc !== exp_dc) begin n_fail++; $display("FAIL rand_done_cycle m=%h q=%h got %0d want %0d", m, q, dc, exp_dc); end
    end
  endtask

  task automatic test_start_held;
    int dones, first_done, ld_cyc10;
    logic [15:0] p;
    dones = 0; first_done = -1; ld_cyc10 = 0; p = 'x;
    multiplicand = 8'd7;
    multiplier   = 8'd6;
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c <= 10 && done) begin
        dones++;
        if (first_done < 0) begin first_done = c; p = product; end
      end
      if (c == 10) ld_cyc10 = int'(cnt_ld);
    end
    start = 1'b0;
    n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL held_done_count got %0d want 1", dones); end
    n_cmp++; if (first_done !== 9) begin n_fail++; $display("FAIL held_done_cycle got %0d want 9", first_done); end
    n_cmp++; if (p !== 16'h002A) begin n_fail++; $display("FAIL held_product got %h want 002a", p); end
    n_cmp++; if (ld_cyc10 !== 1) begin n_fail++; $display("FAIL held_second_accept got %0d want 1", ld_cyc10); end
    for (int c = 0; c < 30 && busy; c++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dc, lds, decs, lv;
    logic [15:0] p;
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_cmp++; if (product !== 16'h0000) begin n_fail++; $display("FAIL midreset_product got %h want 0000", product); end
    n_cmp++; if (cnt_dec !== 1'b0) begin n_fail++; $display("FAIL midreset_cnt_dec got %b want 0", cnt_dec); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_mult(-8'sd2, 8'sd3, dc, lds, decs, p, lv);
    n_cmp++; if (p !== 16'hFFFA) begin n_fail++; $display("FAIL midreset_fresh_product got %h want fffa", p); end
    n_cmp++; if (dc !== 9) begin n_fail++; $display("FAIL midreset_fresh_cycle got %0d want 9", dc); end
  endtask

  task automatic test_zero;
    int dc, lds, decs, lv, exp_dc, exp_lds;
    logic [15:0] p;
    exp_dc  = zskip ? 1 : 9;
    exp_lds = zskip ? 0 : 1;
    do_mult(8'd0, 8'd77, dc, lds, decs, p, lv);
    n_cmp++; if (dc !== exp_dc) begin n_fail++; $display("FAIL zero_done_cycle got %0d want %0d", dc, exp_dc); end
    n_cmp++; if (lds !== exp_lds) begin n_fail++; $display("FAIL zero_ld_count got %0d want %0d", lds, exp_lds); end
    n_cmp++; if (p !== 16'h0000) begin n_fail++; $display("FAIL zero_product got %h want 0000", p); end
  endtask

  initial begin
`ifdef BOOTH_ZERO_SKIP_EN
    zskip = 1'b1;
`else
    zskip = 1'b0;
`endif
    @(negedge clk);
    test_reset;
    test_basic;
    test_corners;
    test_start_held;
    test_reset_mid;
    test_zero;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
